mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle control unit for the ARM-subset core: FSM sequencing a shared-ALU / shared-memory datapath.
//  Supported instructions: ADD/SUB/AND/ORR/CMP (reg/imm), LDR/STR (imm offset), B.
//  Holds the architectural NZCV flags and applies ARM conditional execution.
//  Stretches fetch and memory states on MemReady.
//  Sits beside the datapath in the multicycle top; consumes IR contents and ALUFlags; drives every mux select and write enable.
// PARAMETERS
//  COUNT_W   32   width of performance counters (used only with MC_PERF_CNT_EN)
// PORTS
//  clk         in   1    core clock, all state on rising edge
//  reset       in   1    synchronous, active-high
//  Instr       in   32   instruction register contents
//  ALUFlags    in   4    {N,Z,C,V} from ALU, current cycle
//  MemReady    in   1    memory completes the access this cycle
//  PCWrite     out  1    PC register enable
//  AdrSrc      out  1    memory address: 0=PC, 1=ALUOut
//  MemWrite    out  1    data store enable
//  IRWrite     out  1    instruction register enable
//  RegWrite    out  1    register file write enable
//  ResultSrc   out  2    00=ALUOut, 01=Data reg, 10=ALUResult
//  ALUSrcA     out  1    0=reg A, 1=PC
//  ALUSrcB     out  2    00=reg WriteData, 01=ExtImm, 10=const 4
//  ALUControl  out  2    00 add, 01 sub, 10 and, 11 orr
//  ImmSrc      out  2    00 DP imm8, 01 mem imm12, 10 branch imm24
//  RegSrc      out  2    [0] RA1=R15, [1] RA2=Rd (STR)
//  Flags       out  4    architectural NZCV register
// BEHAVIOUR
//  Reset: state=FETCH; Flags=0; cond_ex_q=0. All enables (PCWrite, IRWrite, RegWrite, MemWrite) are 0 in any cycle with reset=1.
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
//  FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, add, ResultSrc=10.
//    - If MemReady=1: IRWrite=1, PCWrite=1, go to DECODE.
//    - Otherwise: stay in FETCH with all enables 0.
//  DECODE: ALUSrcA=1, ALUSrcB=10, add (PC+8 for R15 reads).
//    - cond_ex_q <= condition(Instr[31:28], Flags); codes 0000-1110 per ARM; 1111 is treated as false.
//    - Next state by op=Instr[27:26]:
//      - 00: I=Instr[25] selects EXECI or EXECR.
//      - 01: MEMADR.
//      - 10: BRANCH.
//      - 11: FETCH, no side effects.
//  MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01; ALUControl = add if U=Instr[23]=1, else sub.
//    - L=Instr[20] selects MEMRD (1) or MEMWR (0).
//  MEMRD: AdrSrc=1; wait until MemReady=1, then go to MEMWB.
//  MEMWB: ResultSrc=01, RegWrite=cond_ex_q, then FETCH.
//  MEMWR: AdrSrc=1, RegSrc[1]=1; MemWrite=cond_ex_q held until MemReady=1, then FETCH.
//    - If cond_ex_q=0: go to FETCH immediately without waiting.
//  EXECR/EXECI: ALUSrcB=00/01, ImmSrc=00; cmd=Instr[24:21] decodes as:
//    - 0100=add, 0010=sub, 0000=and, 1100=orr, 1010(CMP)=sub.
//    - Any other cmd: add with all writes suppressed.
//    - Flag update, when S=Instr[20]=1 and cond_ex_q=1, at the end of this cycle from ALUFlags:
//      - NZ always;
//      - CV only for add/sub/CMP;
//      - and/orr keep the old C and V.
//    - Next state: ALUWB.
//  ALUWB: ResultSrc=00.
//    - RegWrite = cond_ex_q & !CMP & legal cmd.
//    - If Rd=Instr[15:12]=15 and the write occurs: also PCWrite=1.
//  BRANCH: RegSrc[0]=1, ALUSrcA=0, ALUSrcB=01, ImmSrc=10, add, ResultSrc=10.
//    - PCWrite=cond_ex_q; then FETCH.
//  Latency, MemReady tied to 1:
//    - B: 3 cycles.
//    - DP: 4 cycles.
//    - STR: 4 cycles.
//    - LDR: 5 cycles.
//    - Each MemReady=0 cycle adds 1.
//  Flags change only in EXECR/EXECI. A later instruction sees the new flags at its own DECODE.
//  Reset asserted in any state: the next state is FETCH regardless of MemReady; any pending write is dropped.
// CONFIGURATION
//  MC_PERF_CNT_EN defined:
//    - Adds outputs CycleCount[COUNT_W-1:0] and InstrCount[COUNT_W-1:0]. Both are 0 on reset.
//    - CycleCount increments every non-reset cycle.
//    - InstrCount increments on every transition into FETCH from a non-FETCH state, including condition-failed instructions.
//    - Both counters wrap modulo 2^COUNT_W.
//  MC_PERF_CNT_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package mc_ctrl_pkg:
//    - state_t enum;
//    - cond-code localparams (EQ..AL);
//    - ALU op localparams ALU_ADD/SUB/AND/ORR;
//    - cmd encodings;
//    - ResultSrc/ALUSrcB encodings.
//  Sub-module mc_cond_logic:
//    - Owns the Flags register and the condition evaluator.
//    - Inputs: Cond, ALUFlags, FlagWNZ, FlagWCV.
//    - Output: CondEx.
//  The FSM plus decode stays in mc_controller.
// TESTING
//  1. Reset held 2 cycles, then released with MemReady=1:
//     - Enables stay 0 while reset is high.
//     - First cycle after release: FETCH with IRWrite=1, PCWrite=1.
//  2. ADDS R1,R2,#1 (0xE2921001), ALUFlags=0110:
//     - States FETCH/DECODE/EXECI/ALUWB.
//     - RegWrite=1 only in ALUWB.
//     - Flags=0110 afterwards.
//  3. Flags Z=1, then SUBNE R3,R3,R3 (0x10433003):
//     - cond_ex_q=0.
//     - No RegWrite and no flag change.
//     - Still 4 cycles.
//  4. LDR R0,[R1,#4] (0xE5910004) with MemReady low for 3 cycles in MEMRD:
//     - MEMRD lasts 4 cycles.
//     - MEMWB has RegWrite=1 with ResultSrc=01.
//     - Total 8 cycles.
//  5. STR R5,[R1,#-8] (0xE5015008):
//     - MEMADR uses ALUControl=01.
//     - MEMWR has MemWrite=1 and RegSrc[1]=1.
//     - 4 cycles.
//  6. BEQ with Z=0, then B with AL:
//     - First: no PCWrite in BRANCH.
//     - Second: PCWrite=1 in BRANCH.
//     - With MC_PERF_CNT_EN: InstrCount=2, CycleCount=6.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
// Imported by mc_cond_logic and mc_controller.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
      S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
   } state_t;

   localparam logic [3:0] COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010,
                          COND_CC = 4'b0011, COND_MI = 4'b0100, COND_PL = 4'b0101,
                          COND_VS = 4'b0110, COND_VC = 4'b0111, COND_HI = 4'b1000,
                          COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
                          COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110;

   localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11;

   localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100,
                          CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;

   localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
   localparam logic [1:0] SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
   localparam logic [1:0] IMM_DP = 2'b00, IMM_MEM = 2'b01, IMM_BR = 2'b10;
   localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10;

endpackage

// File: rtl/mc_cond_logic.sv
// Architectural NZCV register and ARM condition-code evaluator.
// NZ and CV halves are written independently so logical ops keep C and V.
module mc_cond_logic
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic       FlagWNZ,
   input  logic       FlagWCV,
   output logic       CondEx,
   output logic [3:0] Flags
);

   function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, r;
      n  = f[3];
      z  = f[2];
      cy = f[1];
      v  = f[0];
      case (c)
         COND_EQ: r = z;
         COND_NE: r = ~z;
         COND_CS: r = cy;
         COND_CC: r = ~cy;
         COND_MI: r = n;
         COND_PL: r = ~n;
         COND_VS: r = v;
         COND_VC: r = ~v;
         COND_HI: r = cy & ~z;
         COND_LS: r = ~cy | z;
         COND_GE: r = (n == v);
         COND_LT: r = (n != v);
         COND_GT: r = ~z & (n == v);
         COND_LE: r = z | (n != v);
         COND_AL: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   logic [3:0] flags_r;

   // flag register, each half loaded only when its write strobe is set
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_r <= 4'b0000;
      end else begin
         flags_r[3:2] <= FlagWNZ ? ALUFlags[3:2] : flags_r[3:2];
         flags_r[1:0] <= FlagWCV ? ALUFlags[1:0] : flags_r[1:0];
      end
   end

   assign CondEx = cond_eval(Cond, flags_r);
   assign Flags  = flags_r;

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the ARM-subset core (DP reg/imm, LDR/STR, B).
// Optional MC_PERF_CNT_EN adds CycleCount/InstrCount performance counters.
module mc_controller
   import mc_ctrl_pkg::*;
#(
   parameter int COUNT_W = 32
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   input  logic        MemReady,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUControl,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [3:0]  Flags
`ifdef MC_PERF_CNT_EN
   ,
   output logic [COUNT_W-1:0] CycleCount,
   output logic [COUNT_W-1:0] InstrCount
`endif
);

   state_t     state_r, state_s;
   logic       cond_ex_r, cond_ex_s;
   logic [1:0] dp_alu_s;
   logic       dp_legal_s, dp_cmp_s, dp_arith_s;
   logic       in_exec_s, flag_wnz_s, flag_wcv_s;
   logic       pcw_s, adr_s, mw_s, irw_s, rw_s, asa_s;
   logic [1:0] rs_s, asb_s, alu_s, imm_s, rsrc_s;
   logic       unused_s;

   assign unused_s = ^{Instr[19:16], Instr[11:0]};

   // data-processing cmd decode; CMP is a flag-only subtract
   always_comb begin
      dp_alu_s   = ALU_ADD;
      dp_legal_s = 1'b1;
      dp_cmp_s   = 1'b0;
      dp_arith_s = 1'b1;
      case (Instr[24:21])
         CMD_ADD: dp_alu_s = ALU_ADD;
         CMD_SUB: dp_alu_s = ALU_SUB;
         CMD_CMP: begin dp_alu_s = ALU_SUB; dp_cmp_s = 1'b1; end
         CMD_AND: begin dp_alu_s = ALU_AND; dp_arith_s = 1'b0; end
         CMD_ORR: begin dp_alu_s = ALU_ORR; dp_arith_s = 1'b0; end
         default: begin dp_alu_s = ALU_ADD; dp_legal_s = 1'b0; end
      endcase
   end

   assign in_exec_s  = (state_r == S_EXECR) || (state_r == S_EXECI);
   assign flag_wnz_s = in_exec_s & Instr[20] & cond_ex_r & dp_legal_s;
   assign flag_wcv_s = flag_wnz_s & dp_arith_s;

   mc_cond_logic u_cond (
      .clk      (clk),
      .reset    (reset),
      .Cond     (Instr[31:28]),
      .ALUFlags (ALUFlags),
      .FlagWNZ  (flag_wnz_s),
      .FlagWCV  (flag_wcv_s),
      .CondEx   (cond_ex_s),
      .Flags    (Flags)
   );

   // state register plus condition result captured in DECODE
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= S_FETCH;
         cond_ex_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         cond_ex_r <= (state_r == S_DECODE) ? cond_ex_s : cond_ex_r;
      end
   end

   // next-state and datapath controls
   always_comb begin
      state_s = state_r;
      pcw_s   = 1'b0;
      adr_s   = 1'b0;
      mw_s    = 1'b0;
      irw_s   = 1'b0;
      rw_s    = 1'b0;
      rs_s    = RES_ALUOUT;
      asa_s   = 1'b0;
      asb_s   = SRCB_REG;
      alu_s   = ALU_ADD;
      imm_s   = IMM_DP;
      rsrc_s  = 2'b00;
      case (state_r)
         S_FETCH: begin
            asa_s = 1'b1;
            asb_s = SRCB_FOUR;
            rs_s  = RES_ALURESULT;
            if (MemReady) begin
               irw_s   = 1'b1;
               pcw_s   = 1'b1;
               state_s = S_DECODE;
            end else begin
               state_s = S_FETCH;
            end
         end
         S_DECODE: begin
            asa_s = 1'b1;
            asb_s = SRCB_FOUR;
            case (Instr[27:26])
               OP_DP:   state_s = Instr[25] ? S_EXECI : S_EXECR;
               OP_MEM:  state_s = S_MEMADR;
               OP_BR:   state_s = S_BRANCH;
               default: state_s = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            asb_s   = SRCB_IMM;
            imm_s   = IMM_MEM;
            alu_s   = Instr[23] ? ALU_ADD : ALU_SUB;
            state_s = Instr[20] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            adr_s   = 1'b1;
            state_s = MemReady ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            rs_s    = RES_DATA;
            rw_s    = cond_ex_r;
            state_s = S_FETCH;
         end
         S_MEMWR: begin
            adr_s   = 1'b1;
            rsrc_s  = 2'b10;
            mw_s    = cond_ex_r;
            state_s = (MemReady || !cond_ex_r) ? S_FETCH : S_MEMWR;
         end
         S_EXECR, S_EXECI: begin
            asb_s   = (state_r == S_EXECI) ? SRCB_IMM : SRCB_REG;
            alu_s   = dp_alu_s;
            state_s = S_ALUWB;
         end
         S_ALUWB: begin
            rs_s    = RES_ALUOUT;
            rw_s    = cond_ex_r & dp_legal_s & ~dp_cmp_s;
            pcw_s   = rw_s & (Instr[15:12] == 4'b1111);
            state_s = S_FETCH;
         end
         S_BRANCH: begin
            rsrc_s  = 2'b01;
            asb_s   = SRCB_IMM;
            imm_s   = IMM_BR;
            rs_s    = RES_ALURESULT;
            pcw_s   = cond_ex_r;
            state_s = S_FETCH;
         end
         default: state_s = S_FETCH;
      endcase
   end

   assign PCWrite    = pcw_s & ~reset;
   assign IRWrite    = irw_s & ~reset;
   assign RegWrite   = rw_s & ~reset;
   assign MemWrite   = mw_s & ~reset;
   assign AdrSrc     = adr_s;
   assign ResultSrc  = rs_s;
   assign ALUSrcA    = asa_s;
   assign ALUSrcB    = asb_s;
   assign ALUControl = alu_s;
   assign ImmSrc     = imm_s;
   assign RegSrc     = rsrc_s;

`ifdef MC_PERF_CNT_EN
   logic [COUNT_W-1:0] cycle_cnt_r, instr_cnt_r;

   // an instruction retires on every return to FETCH from another state
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt_r <= {COUNT_W{1'b0}};
         instr_cnt_r <= {COUNT_W{1'b0}};
      end else begin
         cycle_cnt_r <= cycle_cnt_r + COUNT_W'(1'b1);
         instr_cnt_r <= (state_r != S_FETCH && state_s == S_FETCH) ?
                        instr_cnt_r + COUNT_W'(1'b1) : instr_cnt_r;
      end
   end

   assign CycleCount = cycle_cnt_r;
   assign InstrCount = instr_cnt_r;
`else
   localparam logic [31:0] PERF_W_UNUSED = 32'(COUNT_W);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: an instruction-level model expands each
// instruction into per-cycle expected controls; a negedge monitor compares them.
`timescale 1ns/1ps
module tb_mc_controller;

   typedef struct packed {
      logic pcw, adr, mw, irw, rw;
      logic [1:0] rs;
      logic asa;
      logic [1:0] asb, alu, imm, rsrc;
      logic [3:0] fl;
   } ctl_t;

   typedef struct {
      logic        rst;
      logic [31:0] ins;
      logic [3:0]  aluf;
      logic        mrdy;
      ctl_t        exp;
      ctl_t        msk;
      int          cyc;
      int          icnt;
      string       tag;
   } step_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] Instr = 32'h0;
   logic [3:0]  ALUFlags = 4'h0;
   logic        MemReady = 1'b1;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
   logic [3:0]  Flags;
`ifdef MC_PERF_CNT_EN
   logic [31:0] CycleCount, InstrCount;
`endif

   mc_controller #(.COUNT_W(32)) dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags)
`ifdef MC_PERF_CNT_EN
      , .CycleCount(CycleCount), .InstrCount(InstrCount)
`endif
   );

   always #5 clk = ~clk;

   step_t      stim_q[$];
   step_t      exp_q[$];
   int         checks = 0;
   int         failures = 0;
   logic [3:0] m_flags = 4'h0;
   int         m_cyc = 0;
   int         m_icnt = 0;

   // ARM conditions come in complementary pairs selected by cond[0]
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic r;
      case (c[3:1])
         3'd0: r = f[2];
         3'd1: r = f[1];
         3'd2: r = f[3];
         3'd3: r = f[0];
         3'd4: r = f[1] && !f[2];
         3'd5: r = (f[3] == f[0]);
         3'd6: r = !f[2] && (f[3] == f[0]);
         default: r = 1'b1;
      endcase
      if (c[3:1] == 3'd7) return !c[0];
      return r ^ c[0];
   endfunction

   function automatic ctl_t base_msk();
      ctl_t m = '0;
      m.pcw = 1'b1; m.mw = 1'b1; m.irw = 1'b1; m.rw = 1'b1; m.fl = 4'hF;
      return m;
   endfunction

   function automatic logic [3:0] rnd4();
      return 4'($urandom);
   endfunction

   task automatic push(input logic rst, input logic [31:0] ins, input logic [3:0] aluf,
                       input logic mrdy, input ctl_t e, input ctl_t m, input string tag);
      step_t s;
      e.fl = m_flags;
      if (rst) m.fl = 4'h0;
      s.rst = rst; s.ins = ins; s.aluf = aluf; s.mrdy = mrdy;
      s.exp = e; s.msk = m; s.cyc = m_cyc; s.icnt = m_icnt; s.tag = tag;
      stim_q.push_back(s);
      if (rst) begin
         m_cyc = 0; m_icnt = 0; m_flags = 4'h0;
      end else begin
         m_cyc++;
      end
   endtask

   task automatic gen_reset(input logic mrdy);
      ctl_t e = '0;
      ctl_t m = '0;
      m.pcw = 1'b1; m.mw = 1'b1; m.irw = 1'b1; m.rw = 1'b1;
      push(1'b1, 32'h0, rnd4(), mrdy, e, m, "reset");
   endtask

   task automatic gen_fetch(input logic [31:0] ins, input int stall);
      for (int i = 0; i <= stall; i++) begin
         ctl_t e = '0;
         ctl_t m = base_msk();
         m.adr = 1'b1; e.asa = 1'b1; m.asa = 1'b1; e.asb = 2'b10; m.asb = 2'b11;
         m.alu = 2'b11; e.rs = 2'b10; m.rs = 2'b11;
         e.irw = (i == stall); e.pcw = (i == stall);
         push(1'b0, ins, rnd4(), (i == stall), e, m, "fetch");
      end
   endtask

   task automatic gen_decode(input logic [31:0] ins);
      ctl_t e = '0;
      ctl_t m = base_msk();
      e.asa = 1'b1; m.asa = 1'b1; e.asb = 2'b10; m.asb = 2'b11; m.alu = 2'b11;
      push(1'b0, ins, rnd4(), 1'($urandom), e, m, "decode");
   endtask

   task automatic gen_instr(input logic [31:0] ins, input logic [3:0] aluf,
                            input int fstall, input int mstall);
      ctl_t e, m;
      logic pass, legal, cmp, arith;
      logic [1:0] alu;
      logic [3:0] cmd;
      gen_fetch(ins, fstall);
      pass = cond_ok(ins[31:28], m_flags);
      gen_decode(ins);
      cmd = ins[24:21];
      legal = (cmd == 4'd4) || (cmd == 4'd2) || (cmd == 4'd0) || (cmd == 4'd12) || (cmd == 4'd10);
      cmp   = (cmd == 4'd10);
      arith = (cmd == 4'd4) || (cmd == 4'd2) || cmp;
      alu   = (cmd == 4'd2 || cmp) ? 2'b01 : (cmd == 4'd0) ? 2'b10 : (cmd == 4'd12) ? 2'b11 : 2'b00;
      case (ins[27:26])
         2'b00: begin
            e = '0; m = base_msk();
            e.asb = ins[25] ? 2'b01 : 2'b00; m.asb = 2'b11; m.imm = 2'b11;
            e.alu = alu; m.alu = 2'b11;
            push(1'b0, ins, aluf, 1'($urandom), e, m, "exec");
            if (ins[20] && pass && legal) begin
               m_flags[3:2] = aluf[3:2];
               if (arith) m_flags[1:0] = aluf[1:0];
            end
            e = '0; m = base_msk(); m.rs = 2'b11;
            e.rw  = pass && legal && !cmp;
            e.pcw = e.rw && (ins[15:12] == 4'hF);
            push(1'b0, ins, rnd4(), 1'($urandom), e, m, "aluwb");
         end
         2'b01: begin
            e = '0; m = base_msk();
            m.asa = 1'b1; e.asb = 2'b01; m.asb = 2'b11; e.imm = 2'b01; m.imm = 2'b11;
            e.alu = ins[23] ? 2'b00 : 2'b01; m.alu = 2'b11;
            push(1'b0, ins, rnd4(), 1'($urandom), e, m, "memadr");
            if (ins[20]) begin
               for (int i = 0; i <= mstall; i++) begin
                  e = '0; m = base_msk(); e.adr = 1'b1; m.adr = 1'b1;
                  push(1'b0, ins, rnd4(), (i == mstall), e, m, "memrd");
               end
               e = '0; m = base_msk(); e.rs = 2'b01; m.rs = 2'b11; e.rw = pass;
               push(1'b0, ins, rnd4(), 1'($urandom), e, m, "memwb");
            end else begin
               for (int i = 0; i <= (pass ? mstall : 0); i++) begin
                  e = '0; m = base_msk(); e.adr = 1'b1; m.adr = 1'b1;
                  e.rsrc[1] = 1'b1; m.rsrc[1] = 1'b1; e.mw = pass;
                  push(1'b0, ins, rnd4(), pass ? (i == mstall) : 1'($urandom), e, m, "memwr");
               end
            end
         end
         2'b10: begin
            e = '0; m = base_msk();
            e.rsrc[0] = 1'b1; m.rsrc[0] = 1'b1; m.asa = 1'b1; e.asb = 2'b01; m.asb = 2'b11;
            e.imm = 2'b10; m.imm = 2'b11; m.alu = 2'b11; e.rs = 2'b10; m.rs = 2'b11;
            e.pcw = pass;
            push(1'b0, ins, rnd4(), 1'($urandom), e, m, "branch");
         end
         default: ;
      endcase
      m_icnt++;
   endtask

   // monitor: compare every presented cycle against the scoreboard head
   always @(negedge clk) begin : monitor
      step_t s;
      ctl_t  act;
      if (exp_q.size() > 0) begin
         s   = exp_q.pop_front();
         act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags};
         checks++;
         if (((act ^ s.exp) & s.msk) != '0) begin
            failures++;
            $display("FAIL %s instr=%h: got %h required %h (mask %h)", s.tag, s.ins, act, s.exp, s.msk);
         end
`ifdef MC_PERF_CNT_EN
         if (!s.rst) begin
            checks++;
            if (CycleCount != 32'(s.cyc) || InstrCount != 32'(s.icnt)) begin
               failures++;
               $display("FAIL perfcnt %s: got cyc=%0d instr=%0d required cyc=%0d instr=%0d",
                        s.tag, CycleCount, InstrCount, s.cyc, s.icnt);
            end
         end
`endif
      end
   end

   initial begin
      logic [3:0] cmds[5];
      logic [31:0] ins;
      cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

      gen_reset(1'b1);
      gen_reset(1'b1);
      gen_instr(32'hE2921001, 4'b0110, 0, 0);   // ADDS -> Z,C set
      gen_instr(32'h10433003, 4'b1111, 0, 0);   // SUBNE, condition fails
      gen_instr(32'hE5910004, 4'b0000, 0, 3);   // LDR with 3 wait cycles
      gen_instr(32'hE5015008, 4'b0000, 0, 0);   // STR negative offset
      gen_fetch(32'hE5015008, 0);
      gen_decode(32'hE5015008);
      gen_reset(1'b0);                          // abort mid-instruction
      gen_instr(32'h0A000002, 4'b0000, 0, 0);   // BEQ with Z=0
      gen_instr(32'hEA000001, 4'b0000, 0, 0);   // B always
      gen_instr(32'hE2921001, 4'b0000, 2, 0);   // fetch stall

      for (int n = 0; n < 200; n++) begin
         ins = $urandom;
         if ($urandom_range(0, 9) < 6) ins[31:28] = 4'hE;
         ins[27:26] = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 2)) : 2'b11;
         if ($urandom_range(0, 9) < 8) ins[24:21] = cmds[$urandom_range(0, 4)];
         gen_instr(ins, rnd4(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                   $urandom_range(0, 3));
         if (n == 120) gen_reset(1'($urandom));
      end

      while (stim_q.size() > 0) begin
         step_t s;
         s = stim_q.pop_front();
         @(posedge clk);
         #1;
         reset = s.rst; Instr = s.ins; ALUFlags = s.aluf; MemReady = s.mrdy;
         exp_q.push_back(s);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
